// File: rtl/opb_register_simulink2ppc_capture.sv
// OPB slave exposing a fabric-captured 32-bit word to the PowerPC, with NEW/OVERRUN/count status
// and a FREEZE/CLEAR control register. Single clock domain on OPB_Clk.
module opb_register_simulink2ppc_capture #(
   parameter logic [31:0] C_BASEADDR   = 32'h00000000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000000F,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5"
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   output logic                      Sl_xferAck,
   input  logic [31:0]               user_data_in,
   input  logic                      user_data_valid
);

   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_ACK  = 2'd1;
   localparam logic [1:0]  S_WAIT = 2'd2;
   localparam logic [31:0] SPAN   = C_HIGHADDR - C_BASEADDR;

   logic [1:0]  r_state;
   logic [1:0]  w_nextState;
   logic [31:0] r_data;
   logic        r_new;
   logic        r_overrun;
   logic [15:0] r_count;
   logic        r_freeze;

   logic [31:0] w_offset;
   logic        w_inWindow;
   logic [1:0]  w_regSel;
   logic        w_ack;
   logic        w_dataRead;
   logic        w_ctrlWrite;
   logic        w_clear;
   logic        w_capture;
   logic [31:0] w_readWord;
   logic        w_unused;

   // Addresses below the base wrap to huge offsets, so one compare covers both window edges.
   assign w_offset   = OPB_ABus - C_BASEADDR;
   assign w_inWindow = (w_offset <= SPAN);
   assign w_regSel   = w_offset[3:2];

   assign w_ack       = (r_state == S_ACK) && !OPB_Rst;
   assign w_dataRead  = w_ack && OPB_RNW && (w_regSel == 2'd0);
   assign w_ctrlWrite = w_ack && !OPB_RNW && (w_regSel == 2'd2) && OPB_BE[0];
   assign w_clear     = w_ctrlWrite && OPB_DBus[1];
   assign w_capture   = user_data_valid && !r_freeze;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (OPB_select && w_inWindow) w_nextState = S_ACK;
         S_ACK:   w_nextState = S_WAIT;
         S_WAIT:  if (!OPB_select) w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) r_state <= S_IDLE;
      else         r_state <= w_nextState;
   end

   always_comb begin
      w_readWord = '0;
      case (w_regSel)
         2'd0:    w_readWord = r_data;
         2'd1:    w_readWord = {r_new, r_overrun, 14'd0, r_count};
         2'd2:    w_readWord = {r_freeze, 31'd0};
         default: w_readWord = '0;
      endcase
   end

   assign Sl_xferAck = w_ack;
   assign Sl_DBus    = (w_ack && OPB_RNW) ? w_readWord : '0;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   // A capture coinciding with a DATA read keeps NEW set and is not an overrun: the old word was consumed.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         r_data    <= '0;
         r_new     <= 1'b0;
         r_overrun <= 1'b0;
         r_count   <= '0;
         r_freeze  <= 1'b0;
      end else begin
         if (w_capture) r_data <= user_data_in;

         if (w_capture)       r_new <= 1'b1;
         else if (w_dataRead) r_new <= 1'b0;

         if (w_clear)                                r_overrun <= 1'b0;
         else if (w_capture && r_new && !w_dataRead) r_overrun <= 1'b1;

         if (w_clear)        r_count <= '0;
         else if (w_capture) r_count <= r_count + 16'd1;

         if (w_ctrlWrite) r_freeze <= OPB_DBus[0];
      end
   end

   assign w_unused = ^{OPB_seqAddr, OPB_BE, OPB_DBus, C_FAMILY};

endmodule

// File: tb/tb_opb_register_simulink2ppc_capture.sv
// Directed bench: a vector table of OPB reads/writes and fabric strobes, plus hand sequences
// for count wrap, same-cycle capture interactions, held select and reset during an ack.
module tb_opb_register_simulink2ppc_capture;

   localparam int K_READ   = 0;
   localparam int K_WRITE  = 1;
   localparam int K_STROBE = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic [31:0] expData;
      int          expLat;
   } vec_t;

   logic        OPB_Clk;
   logic        OPB_Rst;
   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;
   logic        Sl_xferAck;
   logic [31:0] user_data_in;
   logic        user_data_valid;

   int numChecks = 0;
   int numFails  = 0;
   vec_t vecs[$];

   opb_register_simulink2ppc_capture dut (
      .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
      .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
      .Sl_DBus(Sl_DBus), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
      .Sl_xferAck(Sl_xferAck), .user_data_in(user_data_in), .user_data_valid(user_data_valid)
   );

   initial OPB_Clk = 1'b0;
   always #5 OPB_Clk = ~OPB_Clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      numChecks++;
      if (act !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge OPB_Clk);
      #1;
   endtask

   task automatic strobe(input logic [31:0] d);
      user_data_valid = 1'b1;
      user_data_in    = d;
      tick();
      user_data_valid = 1'b0;
   endtask

   // One OPB transfer; latency is the cycle index of the first ack (-1 if none within the budget).
   task automatic busXfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic strobeOnAck, input logic [31:0] sdata,
                          output logic [31:0] rdata, output int latency);
      rdata      = '0;
      latency    = -1;
      OPB_select = 1'b1;
      OPB_RNW    = rnw;
      OPB_ABus   = addr;
      OPB_BE     = be;
      OPB_DBus   = rnw ? 32'd0 : wdata;
      for (int k = 0; k < 6; k++) begin
         if (strobeOnAck && k == 1) begin
            user_data_valid = 1'b1;
            user_data_in    = sdata;
         end
         @(negedge OPB_Clk);
         if (Sl_xferAck && latency < 0) begin
            latency = k;
            rdata   = Sl_DBus;
         end
         tick();
         user_data_valid = 1'b0;
         if (latency >= 0) break;
      end
      OPB_select = 1'b0;
      OPB_RNW    = 1'b0;
      OPB_ABus   = '0;
      OPB_BE     = '0;
      OPB_DBus   = '0;
      tick();
   endtask

   task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] exp,
                            input logic strobeOnAck, input logic [31:0] sdata);
      logic [31:0] rd;
      int lat;
      busXfer(1'b1, addr, 4'b1111, 32'd0, strobeOnAck, sdata, rd, lat);
      checkOutput({name, "_lat"}, 32'(lat), 32'd1);
      checkOutput(name, rd, exp);
   endtask

   task automatic writeCheck(input string name, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic strobeOnAck, input logic [31:0] sdata);
      logic [31:0] rd;
      int lat;
      busXfer(1'b0, addr, be, wdata, strobeOnAck, sdata, rd, lat);
      checkOutput({name, "_lat"}, 32'(lat), 32'd1);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [31:0] rd;
      int lat;
      if (v.kind == K_STROBE) begin
         strobe(v.data);
      end else begin
         busXfer(v.kind == K_READ, v.addr, v.be, v.data, 1'b0, 32'd0, rd, lat);
         checkOutput($sformatf("vec%0d_lat", idx), 32'(lat), 32'(v.expLat));
         if (v.kind == K_READ && v.expLat == 1)
            checkOutput($sformatf("vec%0d_data", idx), rd, v.expData);
      end
   endtask

   task automatic doReset();
      OPB_Rst = 1'b1;
      tick();
      tick();
      OPB_Rst = 1'b0;
   endtask

   initial begin
      int acks;
      OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
      OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_data_valid = 1'b0;

      // reset state and basic capture
      vecs.push_back('{K_READ,   32'h0, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_READ,   32'h8, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_READ,   32'hC, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_STROBE, 32'h0, 4'h0, 32'hDEADBEEF, 32'h0,        0});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'h80000001, 1});
      vecs.push_back('{K_READ,   32'h0, 4'hF, 32'h0,        32'hDEADBEEF, 1});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'h00000001, 1});
      // overrun and CLEAR
      vecs.push_back('{K_WRITE,  32'h8, 4'hF, 32'h40000000, 32'h0,        1});
      vecs.push_back('{K_STROBE, 32'h0, 4'h0, 32'h00000011, 32'h0,        0});
      vecs.push_back('{K_STROBE, 32'h0, 4'h0, 32'h00000022, 32'h0,        0});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'hC0000002, 1});
      vecs.push_back('{K_WRITE,  32'h8, 4'hF, 32'h40000000, 32'h0,        1});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'h80000000, 1});
      vecs.push_back('{K_READ,   32'h0, 4'hF, 32'h0,        32'h00000022, 1});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_READ,   32'h8, 4'hF, 32'h0,        32'h00000000, 1});
      // FREEZE with BE[0] set, then a write lacking BE[0]
      vecs.push_back('{K_WRITE,  32'h8, 4'h8, 32'h80000000, 32'h0,        1});
      vecs.push_back('{K_READ,   32'h8, 4'hF, 32'h0,        32'h80000000, 1});
      vecs.push_back('{K_STROBE, 32'h0, 4'h0, 32'h00000055, 32'h0,        0});
      vecs.push_back('{K_READ,   32'h0, 4'hF, 32'h0,        32'h00000022, 1});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_WRITE,  32'h8, 4'hF, 32'h00000000, 32'h0,        1});
      vecs.push_back('{K_READ,   32'h8, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_WRITE,  32'h8, 4'h7, 32'h80000000, 32'h0,        1});
      vecs.push_back('{K_READ,   32'h8, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_STROBE, 32'h0, 4'h0, 32'h00000066, 32'h0,        0});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'h80000001, 1});
      // writes to read-only words are acked and discarded; out-of-window is never acked
      vecs.push_back('{K_WRITE,  32'h0, 4'hF, 32'hFFFFFFFF, 32'h0,        1});
      vecs.push_back('{K_READ,   32'h0, 4'hF, 32'h0,        32'h00000066, 1});
      vecs.push_back('{K_READ,   32'h4, 4'hF, 32'h0,        32'h00000001, 1});
      vecs.push_back('{K_WRITE,  32'hC, 4'hF, 32'h12345678, 32'h0,        1});
      vecs.push_back('{K_READ,   32'hC, 4'hF, 32'h0,        32'h00000000, 1});
      vecs.push_back('{K_READ,   32'h10, 4'hF, 32'h0,       32'h00000000, -1});
      vecs.push_back('{K_WRITE,  32'h14, 4'hF, 32'hFFFFFFFF, 32'h0,       -1});

      doReset();
      @(negedge OPB_Clk);
      checkOutput("resetAck", {31'd0, Sl_xferAck}, 32'd0);
      checkOutput("resetDBus", Sl_DBus, 32'd0);
      checkOutput("constOuts", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
      tick();

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

      // count wrap after 65536 captures
      doReset();
      for (int i = 0; i < 65536; i++) begin
         user_data_valid = 1'b1;
         user_data_in    = 32'(i);
         tick();
      end
      user_data_valid = 1'b0;
      readCheck("wrapStatus", 32'h4, 32'hC0000000, 1'b0, 32'd0);
      readCheck("wrapData", 32'h0, 32'h0000FFFF, 1'b0, 32'd0);

      // capture during an acked DATA read
      writeCheck("clr1", 32'h8, 4'hF, 32'h40000000, 1'b0, 32'd0);
      strobe(32'h000000A1);
      readCheck("readRaceData", 32'h0, 32'h000000A1, 1'b1, 32'h000000B2);
      readCheck("readRaceStatus", 32'h4, 32'h80000002, 1'b0, 32'd0);
      readCheck("readRaceNewData", 32'h0, 32'h000000B2, 1'b0, 32'd0);

      // CLEAR in the same cycle as a capture
      strobe(32'h1);
      strobe(32'h2);
      writeCheck("clrRace", 32'h8, 4'hF, 32'h40000000, 1'b1, 32'h000000C3);
      readCheck("clrRaceStatus", 32'h4, 32'h80000000, 1'b0, 32'd0);
      readCheck("clrRaceData", 32'h0, 32'h000000C3, 1'b0, 32'd0);

      // FREEZE write with a same-cycle strobe still captures it
      writeCheck("frzRace", 32'h8, 4'hF, 32'h80000000, 1'b1, 32'h000000D4);
      readCheck("frzRaceData", 32'h0, 32'h000000D4, 1'b0, 32'd0);
      readCheck("frzRaceStatus", 32'h4, 32'h00000001, 1'b0, 32'd0);
      strobe(32'h000000E5);
      readCheck("frozenData", 32'h0, 32'h000000D4, 1'b0, 32'd0);
      writeCheck("unfreeze", 32'h8, 4'hF, 32'h00000000, 1'b0, 32'd0);

      // select held for several cycles yields exactly one ack
      acks = 0;
      OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = 32'h4; OPB_BE = 4'hF;
      for (int k = 0; k < 6; k++) begin
         @(negedge OPB_Clk);
         if (Sl_xferAck) acks++;
         tick();
      end
      OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0;
      tick();
      checkOutput("holdSelectAcks", 32'(acks), 32'd1);

      // reset asserted while the slave is in its ack cycle
      strobe(32'h00000077);
      writeCheck("frzBeforeRst", 32'h8, 4'h8, 32'h80000000, 1'b0, 32'd0);
      OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = 32'h0; OPB_BE = 4'hF;
      tick();
      OPB_Rst = 1'b1;
      OPB_select = 1'b0;
      tick();
      OPB_Rst = 1'b0;
      @(negedge OPB_Clk);
      checkOutput("rstAckAfter", {31'd0, Sl_xferAck}, 32'd0);
      checkOutput("rstDBusAfter", Sl_DBus, 32'd0);
      tick();
      readCheck("rstData", 32'h0, 32'h00000000, 1'b0, 32'd0);
      readCheck("rstStatus", 32'h4, 32'h00000000, 1'b0, 32'd0);
      readCheck("rstCtrl", 32'h8, 32'h00000000, 1'b0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
